control_unit_mc: RTL and testbench

Multi-cycle control unit that accepts one 32-bit RV64 instruction at a time over a valid/ready handshake and sequences the control inputs of the register-bank/adder/data-memory datapath. It covers ld, sd, add, sub and addi. It decodes the fields, generates the sign-extended immediate, and steps through DECODE/EXEC/MEM/WB states. Its outputs connect port-for-port to the datapath's control inputs.

---
 rtl/control_pkg.sv | 33 +++
 rtl/control_unit_mc_imm_gen.sv | 30 +++
 rtl/control_unit_mc.sv | 157 +++++++++++++++
 tb/tb_control_unit_mc.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared constants for the multi-cycle control unit:
// opcode/funct fields, FSM state codes, operation codes, default widths.
package control_pkg;

   localparam int XLEN_DEF = 64;
   localparam int ILEN_DEF = 32;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;

   localparam logic [2:0] F3_D    = 3'b011;
   localparam logic [2:0] F3_ADD  = 3'b000;

   localparam logic [6:0] F7_ADD  = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_ERR    = 3'd5;

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_LD   = 3'd1;
   localparam logic [2:0] OP_SD   = 3'd2;
   localparam logic [2:0] OP_ADD  = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_ADDI = 3'd5;

endpackage

// File: rtl/control_unit_mc_imm_gen.sv
// imm_gen: combinational immediate extraction and sign extension.
// Ports: instr_i (instruction), op_i (decoded op code), imm_o (XLEN immediate).
module imm_gen
   import control_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int ILEN = ILEN_DEF
) (
   input  logic [ILEN-1:0] instr_i,
   input  logic [2:0]      op_i,
   output logic [XLEN-1:0] imm_o
);

   logic [11:0] imm_i12;
   logic [11:0] imm_s12;

   assign imm_i12 = instr_i[31:20];
   assign imm_s12 = {instr_i[31:25], instr_i[11:7]};

   always_comb begin
      imm_o = '0;
      unique case (1'b1)
         (op_i == OP_LD),
         (op_i == OP_ADDI): imm_o = {{(XLEN-12){instr_i[31]}}, imm_i12};
         (op_i == OP_SD):   imm_o = {{(XLEN-12){instr_i[31]}}, imm_s12};
         default:           imm_o = '0;
      endcase
   end

endmodule

// File: rtl/control_unit_mc.sv
// control_unit_mc: multi-cycle sequencer for ld/sd/add/sub/addi.
// Ports: clk, reset, instr_valid/instruction/instr_ready handshake in;
// registered field, immediate, mux-select, enable, done, illegal outputs.
module control_unit_mc
   import control_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int ILEN = ILEN_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            instr_valid,
   input  logic [ILEN-1:0] instruction,
   output logic            instr_ready,
   output logic [XLEN-1:0] immediate,
   output logic [4:0]      readRegister1,
   output logic [4:0]      readRegister2,
   output logic [4:0]      writeRegister,
   output logic            writeEnable_DataMemory,
   output logic            writeEnable_Registers,
   output logic            muxSelect_SumVsReadData,
   output logic            muxSelect_ImmVsDataout2,
   output logic            SumOrSub,
   output logic            done,
   output logic            illegal
);

   logic [2:0]      state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [ILEN-1:0] instr_q, instr_d;

   logic [XLEN-1:0] imm_q;
   logic [4:0]      rs1_q, rs2_q, rd_q;
   logic            we_dm_q, we_rf_q;
   logic            sel_rd_q, sel_imm_q, sub_q;
   logic            done_q, ill_q, ready_q;

   logic [6:0]      opc, f7;
   logic [2:0]      f3;
   logic [2:0]      dec_op;
   logic [XLEN-1:0] imm_w;
   logic            hs;

   assign opc = instr_q[6:0];
   assign f3  = instr_q[14:12];
   assign f7  = instr_q[31:25];
   assign hs  = instr_valid & ready_q;

   always_comb begin
      dec_op = OP_NONE;
      unique case (1'b1)
         (opc == OPC_LOAD  && f3 == F3_D):   dec_op = OP_LD;
         (opc == OPC_STORE && f3 == F3_D):   dec_op = OP_SD;
         (opc == OPC_OP && f3 == F3_ADD
            && f7 == F7_ADD):                dec_op = OP_ADD;
         (opc == OPC_OP && f3 == F3_ADD
            && f7 == F7_SUB):                dec_op = OP_SUB;
         (opc == OPC_OPIMM && f3 == F3_ADD): dec_op = OP_ADDI;
         default:                            dec_op = OP_NONE;
      endcase
   end

   imm_gen #(
      .XLEN (XLEN),
      .ILEN (ILEN)
   ) u_imm (
      .instr_i (instr_q),
      .op_i    (dec_op),
      .imm_o   (imm_w)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      instr_d = instr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (hs) begin
               instr_d = instruction;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            op_d    = dec_op;
            state_d = (dec_op == OP_NONE) ? ST_ERR : ST_EXEC;
         end
         ST_EXEC: begin
            state_d = (op_q == OP_LD || op_q == OP_SD) ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            state_d = (op_q == OP_LD) ? ST_WB : ST_IDLE;
         end
         ST_WB:   state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes are registered against the next state so they line up
   // with the cycle the FSM spends in that state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_NONE;
         instr_q   <= '0;
         imm_q     <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         we_dm_q   <= 1'b0;
         we_rf_q   <= 1'b0;
         sel_rd_q  <= 1'b0;
         sel_imm_q <= 1'b0;
         sub_q     <= 1'b0;
         done_q    <= 1'b0;
         ill_q     <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         instr_q <= instr_d;
         if (state_q == ST_DECODE) begin
            imm_q     <= imm_w;
            rs1_q     <= instr_q[19:15];
            rs2_q     <= (dec_op == OP_ADD || dec_op == OP_SUB ||
                          dec_op == OP_SD) ? instr_q[24:20] : 5'd0;
            rd_q      <= (dec_op == OP_ADD || dec_op == OP_SUB ||
                          dec_op == OP_ADDI || dec_op == OP_LD) ?
                         instr_q[11:7] : 5'd0;
            sel_rd_q  <= (dec_op == OP_LD);
            sel_imm_q <= (dec_op == OP_LD || dec_op == OP_SD ||
                          dec_op == OP_ADDI);
            sub_q     <= (dec_op == OP_SUB);
         end
         we_dm_q <= (state_d == ST_MEM) && (op_q == OP_SD);
         we_rf_q <= (state_d == ST_WB) && (rd_q != 5'd0);
         done_q  <= (state_d == ST_WB) ||
                    ((state_d == ST_MEM) && (op_q == OP_SD));
         ill_q   <= (state_d == ST_ERR);
         ready_q <= (state_d == ST_IDLE);
      end
   end

   assign instr_ready             = ready_q;
   assign immediate               = imm_q;
   assign readRegister1           = rs1_q;
   assign readRegister2           = rs2_q;
   assign writeRegister           = rd_q;
   assign writeEnable_DataMemory  = we_dm_q;
   assign writeEnable_Registers   = we_rf_q;
   assign muxSelect_SumVsReadData = sel_rd_q;
   assign muxSelect_ImmVsDataout2 = sel_imm_q;
   assign SumOrSub                = sub_q;
   assign done                    = done_q;
   assign illegal                 = ill_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed testbench for control_unit_mc.
// Cycle k is observed #1 after the k-th rising edge following the handshake.
module tb_control_unit_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [31:0] instruction;
   logic        instr_ready;
   logic [63:0] immediate;
   logic [4:0]  readRegister1, readRegister2, writeRegister;
   logic        writeEnable_DataMemory, writeEnable_Registers;
   logic        muxSelect_SumVsReadData, muxSelect_ImmVsDataout2;
   logic        SumOrSub, done, illegal;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   control_unit_mc dut (
      .clk                     (clk),
      .reset                   (reset),
      .instr_valid             (instr_valid),
      .instruction             (instruction),
      .instr_ready             (instr_ready),
      .immediate               (immediate),
      .readRegister1           (readRegister1),
      .readRegister2           (readRegister2),
      .writeRegister           (writeRegister),
      .writeEnable_DataMemory  (writeEnable_DataMemory),
      .writeEnable_Registers   (writeEnable_Registers),
      .muxSelect_SumVsReadData (muxSelect_SumVsReadData),
      .muxSelect_ImmVsDataout2 (muxSelect_ImmVsDataout2),
      .SumOrSub                (SumOrSub),
      .done                    (done),
      .illegal                 (illegal)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ready, we_dm, we_rf, done, illegal packed into one vector
   function automatic logic [4:0] strobes();
      return {instr_ready, writeEnable_DataMemory, writeEnable_Registers,
              done, illegal};
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_strb"}, {59'd0, strobes()}, 64'd0);
      chk({tag, "_imm"}, immediate, 64'd0);
      chk({tag, "_regs"}, {49'd0, readRegister1, readRegister2,
                           writeRegister}, 64'd0);
      chk({tag, "_mux"}, {61'd0, muxSelect_SumVsReadData,
                          muxSelect_ImmVsDataout2, SumOrSub}, 64'd0);
   endtask

   // Present instr for one edge; on return we are in cycle 1.
   task automatic issue(input logic [31:0] w);
      instruction = w;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      instr_valid = 1'b0;
      instruction = '0;
      step();
      step();
      chk_all_zero("reset");
      reset = 1'b0;
      step();
      chk("ready_after_reset", {63'd0, instr_ready}, 64'd1);

      // addi x5,x0,-3
      issue(32'hFFD00293);
      chk("addi_c1_strb", {59'd0, strobes()}, 64'd0);
      step();
      chk("addi_imm", immediate, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("addi_rd", {59'd0, writeRegister}, 64'd5);
      chk("addi_selimm", {63'd0, muxSelect_ImmVsDataout2}, 64'd1);
      chk("addi_c2_strb", {59'd0, strobes()}, 64'd0);
      step();
      chk("addi_c3_strb", {59'd0, strobes()}, 64'b00110);
      step();
      chk("addi_c4_strb", {59'd0, strobes()}, 64'b10000);

      // sub x7,x1,x2
      issue(32'h402083B3);
      step();
      chk("sub_rs", {54'd0, readRegister1, readRegister2},
          {54'd0, 5'd1, 5'd2});
      chk("sub_mux", {61'd0, muxSelect_SumVsReadData,
                      muxSelect_ImmVsDataout2, SumOrSub}, 64'b001);
      chk("sub_imm", immediate, 64'd0);
      step();
      chk("sub_c3_strb", {59'd0, strobes()}, 64'b00110);
      chk("sub_rd", {59'd0, writeRegister}, 64'd7);
      step();
      chk("sub_c4_strb", {59'd0, strobes()}, 64'b10000);

      // sd x6,8(x2)
      issue(32'h00613423);
      step();
      chk("sd_imm", immediate, 64'd8);
      chk("sd_regs", {49'd0, readRegister1, readRegister2, writeRegister},
          {49'd0, 5'd2, 5'd6, 5'd0});
      chk("sd_mux", {61'd0, muxSelect_SumVsReadData,
                     muxSelect_ImmVsDataout2, SumOrSub}, 64'b010);
      chk("sd_c2_strb", {59'd0, strobes()}, 64'd0);
      step();
      chk("sd_c3_strb", {59'd0, strobes()}, 64'b01010);
      step();
      chk("sd_c4_strb", {59'd0, strobes()}, 64'b10000);

      // ld x8,16(x3)
      issue(32'h0101B403);
      step();
      chk("ld_imm", immediate, 64'd16);
      chk("ld_regs", {49'd0, readRegister1, readRegister2, writeRegister},
          {49'd0, 5'd3, 5'd0, 5'd8});
      chk("ld_mux", {61'd0, muxSelect_SumVsReadData,
                     muxSelect_ImmVsDataout2, SumOrSub}, 64'b110);
      step();
      chk("ld_c3_strb", {59'd0, strobes()}, 64'd0);
      step();
      chk("ld_c4_strb", {59'd0, strobes()}, 64'b00110);
      step();
      chk("ld_c5_strb", {59'd0, strobes()}, 64'b10000);

      // illegal word, valid held and word changed while busy
      instruction = 32'h0;
      instr_valid = 1'b1;
      step();
      instruction = 32'hFFD00293;
      chk("ill_c1_strb", {59'd0, strobes()}, 64'd0);
      step();
      chk("ill_c2_strb", {59'd0, strobes()}, 64'b00001);
      chk("ill_c2_mux", {61'd0, muxSelect_SumVsReadData,
                         muxSelect_ImmVsDataout2, SumOrSub}, 64'b000);
      step();
      instr_valid = 1'b0;
      chk("ill_c3_strb", {59'd0, strobes()}, 64'b10000);
      step();
      chk("ill_c4_idle", {59'd0, strobes()}, 64'b10000);

      // add x3,x1,x2 interrupted by reset in cycle 2
      issue(32'h002081B3);
      step();
      chk("add_c2_rs1", {59'd0, readRegister1}, 64'd1);
      reset = 1'b1;
      step();
      chk_all_zero("midrst");
      reset = 1'b0;
      step();
      chk("midrst_ready", {59'd0, strobes()}, 64'b10000);
      step();
      chk("midrst_quiet", {59'd0, strobes()}, 64'b10000);

      // addi x0,x0,1
      issue(32'h00100013);
      step();
      chk("x0_rd", {59'd0, writeRegister}, 64'd0);
      step();
      chk("x0_c3_strb", {59'd0, strobes()}, 64'b00010);
      step();
      chk("x0_c4_strb", {59'd0, strobes()}, 64'b10000);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
